delay_ctrl: RTL and testbench

- Sequencer for the RAM-based audio delay line (address counter + dual-address RAM).
- Replaces the free-running counter-plus-offset addressing with explicit record/playback control.
- Fills the RAM with exactly `offset` samples, then reads and writes on every sample strobe.
- Produces RAM write/read enables and addresses, and an output-valid flag aligned with RAM read data.

---
 rtl/delay_ctrl_pkg.sv | 14 +
 rtl/delay_ptr.sv | 42 ++++
 rtl/delay_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_delay_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/delay_ctrl_pkg.sv
// rtl/delay_ctrl_pkg.sv - shared types and default sizing for the delay line sequencer
package delay_ctrl_pkg;

  // Sequencer states: idle, initial fill of the delay line, steady-state streaming
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int A_WIDTH_DEF = 9;
  localparam int RD_LAT_DEF  = 1;

endpackage

// File: rtl/delay_ptr.sv
// rtl/delay_ptr.sv - wrapping address pointer with clear, load and increment
module delay_ptr
  import delay_ctrl_pkg::*;
#(
  parameter int W = A_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // Next pointer: clear wins over load, load wins over increment; natural wrap at 2**W
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (load) begin
      ptr_d = load_val;
    end else if (inc) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  // Pointer register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/delay_ctrl.sv
// rtl/delay_ctrl.sv - record/playback sequencer for the RAM delay line (option: DELAY_CTRL_RETUNE_EN)
module delay_ctrl
  import delay_ctrl_pkg::*;
#(
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int RD_LAT  = RD_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               sample_valid,
  input  logic [A_WIDTH-1:0] offset,
  output logic               wr_en,
  output logic [A_WIDTH-1:0] wr_addr,
  output logic               rd_en,
  output logic [A_WIDTH-1:0] rd_addr,
  output logic               out_valid,
  output logic               running,
  output logic               cfg_err
);

  state_t               state_q, state_d;
  logic [A_WIDTH-1:0]   dly_q, dly_d;
  logic [A_WIDTH-1:0]   fill_cnt_q, fill_cnt_d;
  logic                 wr_en_q, wr_en_d;
  logic [A_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic                 rd_en_q, rd_en_d;
  logic [A_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                 skip_q, skip_d;
  logic [RD_LAT-1:0]    vpipe_q, vpipe_d;
  logic                 running_q, running_d;
  logic                 cfg_err_q, cfg_err_d;

`ifdef DELAY_CTRL_RETUNE_EN
  logic                 pend_q, pend_d;
  logic [A_WIDTH-1:0]   new_dly_q, new_dly_d;
  logic [A_WIDTH-1:0]   off_prev_q;
`endif

  logic                 w_clr, w_inc;
  logic                 r_clr, r_inc, r_load;
  logic [A_WIDTH-1:0]   r_load_val;
  logic [A_WIDTH-1:0]   wptr, rptr;

  delay_ptr #(.W(A_WIDTH)) u_wptr (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (w_inc),
    .ptr      (wptr)
  );

  delay_ptr #(.W(A_WIDTH)) u_rptr (
    .clk      (clk),
    .rst      (rst),
    .clr      (r_clr),
    .load     (r_load),
    .load_val (r_load_val),
    .inc      (r_inc),
    .ptr      (rptr)
  );

  // Sequencer next-state and registered-output decode; stop overrides everything
  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    fill_cnt_d = fill_cnt_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = '0;
    rd_en_d    = 1'b0;
    rd_addr_d  = '0;
    skip_d     = 1'b0;
    cfg_err_d  = 1'b0;
    w_clr      = 1'b0;
    w_inc      = 1'b0;
    r_clr      = 1'b0;
    r_inc      = 1'b0;
    r_load     = 1'b0;
    r_load_val = '0;
`ifdef DELAY_CTRL_RETUNE_EN
    pend_d     = 1'b0;
    new_dly_d  = new_dly_q;
`endif

    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (offset != '0) begin
              dly_d      = offset;
              fill_cnt_d = '0;
              w_clr      = 1'b1;
              r_clr      = 1'b1;
              state_d    = FILL;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end

        FILL: begin
          if (sample_valid) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = wptr;
            w_inc      = 1'b1;
            fill_cnt_d = fill_cnt_q + 1'b1;
            if (fill_cnt_d == dly_q) begin
              state_d = RUN;
            end
          end
        end

        RUN: begin
          if (sample_valid) begin
            wr_en_d   = 1'b1;
            rd_en_d   = 1'b1;
            wr_addr_d = wptr;
            rd_addr_d = rptr;
            w_inc     = 1'b1;
            r_inc     = 1'b1;
`ifdef DELAY_CTRL_RETUNE_EN
            // Apply a pending delay change: read at the new gap now, resume one past it
            if (pend_q) begin
              rd_addr_d  = wptr - new_dly_q;
              r_inc      = 1'b0;
              r_load     = 1'b1;
              r_load_val = wptr - new_dly_q + 1'b1;
              dly_d      = new_dly_q;
              skip_d     = 1'b1;
            end
`endif
          end
`ifdef DELAY_CTRL_RETUNE_EN
          // Track the offset input: nonzero differing values become pending, zero is flagged once
          if (offset == '0) begin
            if (off_prev_q != '0) begin
              cfg_err_d = 1'b1;
            end
          end else if (offset != dly_d) begin
            pend_d    = 1'b1;
            new_dly_d = offset;
          end
`endif
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign running_d = (state_d == RUN);
  assign vpipe_d   = (vpipe_q << 1) | RD_LAT'(rd_en_q & ~skip_q);

  // State and output registers; reset drops every output and the read-valid pipe
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      dly_q      <= '0;
      fill_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      skip_q     <= 1'b0;
      vpipe_q    <= '0;
      running_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      fill_cnt_q <= fill_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      skip_q     <= skip_d;
      vpipe_q    <= vpipe_d;
      running_q  <= running_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

`ifdef DELAY_CTRL_RETUNE_EN
  // Retune bookkeeping: pending new delay and previous offset for zero-edge detection
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q     <= 1'b0;
      new_dly_q  <= '0;
      off_prev_q <= '0;
    end else begin
      pend_q     <= pend_d;
      new_dly_q  <= new_dly_d;
      off_prev_q <= offset;
    end
  end
`endif

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign out_valid = vpipe_q[RD_LAT-1];
  assign running   = running_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_delay_ctrl.sv
// tb/tb_delay_ctrl.sv - directed self-checking bench for delay_ctrl
module tb_delay_ctrl;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          sample_valid = 1'b0;
  logic [AW-1:0] offset = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          out_valid;
  logic          running;
  logic          cfg_err;

  int n_vec = 0;
  int n_err = 0;

  delay_ctrl #(.A_WIDTH(AW), .RD_LAT(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .sample_valid (sample_valid),
    .offset       (offset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .out_valid    (out_valid),
    .running      (running),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] o);
    offset = o;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic all_zero(input string tag);
    logic [31:0] v;
    v = {19'd0, wr_en, wr_addr, rd_en, rd_addr, out_valid, running, cfg_err};
    chk(tag, v, 32'd0);
  endtask

  // One isolated strobe: check the write/read issue, then the read-valid a cycle later
  task automatic sample_chk(input string tag, input logic ewr, input int ewa,
                            input logic erd, input int era);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    chk({tag, " wr_en"}, wr_en, ewr);
    if (ewr) chk({tag, " wr_addr"}, wr_addr, ewa);
    chk({tag, " rd_en"}, rd_en, erd);
    if (erd) chk({tag, " rd_addr"}, rd_addr, era);
    tick();
    chk({tag, " out_valid"}, out_valid, erd);
  endtask

  initial begin
    logic [AW-1:0] gap;

    // Reset hold with start/sample toggling
    for (int i = 0; i < 3; i++) begin
      start        = i[0];
      sample_valid = ~i[0];
      tick();
      all_zero($sformatf("reset_hold%0d", i));
    end
    start        = 1'b0;
    sample_valid = 1'b0;
    rst          = 1'b1;
    tick();
    chk("idle running", running, 1'b0);
    sample_chk("idle_sample", 1'b0, 0, 1'b0, 0);

    // Fill with delay 4, then run
    do_start(4'd4);
    sample_chk("fill0", 1'b1, 0, 1'b0, 0);
    sample_chk("fill1", 1'b1, 1, 1'b0, 0);
    sample_chk("fill2", 1'b1, 2, 1'b0, 0);
    chk("fill running", running, 1'b0);
    sample_chk("fill3", 1'b1, 3, 1'b0, 0);
    chk("run running", running, 1'b1);
    sample_chk("run0", 1'b1, 4, 1'b1, 0);
    sample_chk("run1", 1'b1, 5, 1'b1, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop running", running, 1'b0);

    // Maximum delay with back-to-back strobes across the wrap
    do_start(4'd15);
    sample_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      chk($sformatf("wrap%0d wr_en", k), wr_en, 1'b1);
      chk($sformatf("wrap%0d wr_addr", k), wr_addr, k % 16);
      chk($sformatf("wrap%0d rd_en", k), rd_en, (k >= 15));
      if (k >= 15) begin
        chk($sformatf("wrap%0d rd_addr", k), rd_addr, (k - 15) % 16);
        gap = wr_addr - rd_addr;
        chk($sformatf("wrap%0d gap", k), gap, 15);
      end
      if (k >= 1) chk($sformatf("wrap%0d out_valid", k), out_valid, (k >= 16));
    end
    sample_valid = 1'b0;
    tick();
    chk("wrap tail out_valid", out_valid, 1'b1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();

    // Zero offset is rejected
    do_start(4'd0);
    chk("zero cfg_err", cfg_err, 1'b1);
    tick();
    chk("zero cfg_err drop", cfg_err, 1'b0);
    chk("zero running", running, 1'b0);
    sample_chk("zero_sample", 1'b0, 0, 1'b0, 0);
    chk("zero cfg_err quiet", cfg_err, 1'b0);

    // stop + start + sample together in RUN
    do_start(4'd2);
    sample_chk("pri_fill0", 1'b1, 0, 1'b0, 0);
    sample_chk("pri_fill1", 1'b1, 1, 1'b0, 0);
    sample_chk("pri_run0", 1'b1, 2, 1'b1, 0);
    stop         = 1'b1;
    start        = 1'b1;
    sample_valid = 1'b1;
    tick();
    stop         = 1'b0;
    start        = 1'b0;
    sample_valid = 1'b0;
    chk("pri wr_en", wr_en, 1'b0);
    chk("pri rd_en", rd_en, 1'b0);
    chk("pri running", running, 1'b0);
    tick();
    chk("pri out_valid", out_valid, 1'b0);
    sample_chk("pri_after", 1'b0, 0, 1'b0, 0);

    // Reset while streaming, then restart
    do_start(4'd3);
    sample_valid = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("mid rd_en before reset", rd_en, 1'b1);
    rst = 1'b0;
    tick();
    all_zero("mid_reset");
    rst          = 1'b1;
    sample_valid = 1'b0;
    tick();
    all_zero("mid_release");
    do_start(4'd2);
    sample_chk("restart0", 1'b1, 0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
